// File: rtl/tank_sprite_scheduler.sv
// tank_sprite_scheduler
//   Shares one synchronous tank-sprite ROM among up to N_SLOTS on-screen tanks.
//   During horizontal blanking (fetch starts at DrawX==640) it copies the
//   32-texel row of each tank that crosses the next scanline into a per-slot
//   row buffer. During active video it picks the lowest-numbered slot with a
//   non-transparent texel and emits its palette index one cycle later.
//
// Ports
//   vga_clk, Reset      pixel clock, synchronous active-high reset
//   DrawX, DrawY        current pixel column / line from the VGA timer
//   slot_valid/x/y/dir  per-slot tank state (sampled only at fetch start)
//   rom_address, rom_q  shared sprite ROM port ({dir,row,col}, 1-cycle read)
//   sprite_hit/idx/slot registered render result for the previous pixel
//   fetch_busy          high while the fetch FSM is not idle
//   collision           sticky multi-sprite overlap flag
//
// Build option
//   TANK_SCHED_COLLIDE_EN  when defined, collision sets on any active pixel
//                          with two or more live slots and clears at the
//                          frame origin; otherwise collision is tied to 0.
module tank_sprite_scheduler #(
  parameter int N_SLOTS = 4
) (
  input  logic                   vga_clk,
  input  logic                   Reset,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  input  logic [N_SLOTS-1:0]     slot_valid,
  input  logic [10*N_SLOTS-1:0]  slot_x,
  input  logic [10*N_SLOTS-1:0]  slot_y,
  input  logic [2*N_SLOTS-1:0]   slot_dir,
  output logic [11:0]            rom_address,
  input  logic [3:0]             rom_q,
  output logic                   sprite_hit,
  output logic [3:0]             sprite_idx,
  output logic [1:0]             sprite_slot,
  output logic                   fetch_busy,
  output logic                   collision
);

  typedef enum logic [1:0] {IDLE, SCAN, FETCH, DRAIN} state_t;

  localparam logic [1:0] LAST_SLOT = 2'(N_SLOTS - 1);

  state_t               state_reg, state_next;
  logic [1:0]           slot_reg, slot_next;
  logic [4:0]           col_reg, col_next;
  logic [9:0]           next_line_reg;
  logic [N_SLOTS-1:0]   valid_sh_reg;
  logic [N_SLOTS-1:0]   row_valid_reg;
  logic [9:0]           x_sh_reg   [N_SLOTS];
  logic [9:0]           y_sh_reg   [N_SLOTS];
  logic [1:0]           dir_sh_reg [N_SLOTS];

  // ROM data arrives one cycle after the address, so the buffer write is
  // delayed by one cycle using these registered write controls.
  logic                 wr_en_reg;
  logic [1:0]           wr_slot_reg;
  logic [4:0]           wr_col_reg;

  logic                 fetch_start;
  logic                 last_slot;
  logic [9:0]           scan_row;
  logic                 scan_hit;

  logic [N_SLOTS-1:0]   live;
  logic [4*N_SLOTS-1:0] texel_flat;
  logic                 hit_next;
  logic [3:0]           idx_next;
  logic [1:0]           slot_win;
  logic                 sprite_hit_reg;
  logic [3:0]           sprite_idx_reg;
  logic [1:0]           sprite_slot_reg;

  assign fetch_start = (state_reg == IDLE) && (DrawX == 10'd640);
  assign last_slot   = (slot_reg == LAST_SLOT);
  // Unsigned wrap: a sprite starting below next_line yields a huge row.
  assign scan_row    = next_line_reg - y_sh_reg[slot_reg];
  assign scan_hit    = valid_sh_reg[slot_reg] && (next_line_reg < 10'd480) &&
                       (scan_row < 10'd32);

  // ---------------- fetch FSM ----------------
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state_reg   <= IDLE;
      slot_reg    <= 2'd0;
      col_reg     <= 5'd0;
      wr_en_reg   <= 1'b0;
      wr_slot_reg <= 2'd0;
      wr_col_reg  <= 5'd0;
    end else begin
      state_reg   <= state_next;
      slot_reg    <= slot_next;
      col_reg     <= col_next;
      wr_en_reg   <= (state_reg == FETCH);
      wr_slot_reg <= slot_reg;
      wr_col_reg  <= col_reg;
    end
  end

  always_comb begin
    state_next  = state_reg;
    slot_next   = slot_reg;
    col_next    = col_reg;
    rom_address = 12'd0;
    fetch_busy  = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (fetch_start) begin
          state_next = SCAN;
          slot_next  = 2'd0;
        end
      end
      SCAN: begin
        if (scan_hit) begin
          state_next = FETCH;
          col_next   = 5'd0;
        end else if (last_slot) begin
          state_next = DRAIN;
        end else begin
          slot_next = slot_reg + 2'd1;
        end
      end
      FETCH: begin
        rom_address = {dir_sh_reg[slot_reg], scan_row[4:0], col_reg};
        if (col_reg == 5'd31) begin
          if (last_slot) begin
            state_next = DRAIN;
          end else begin
            state_next = SCAN;
            slot_next  = slot_reg + 2'd1;
          end
        end else begin
          col_next = col_reg + 5'd1;
        end
      end
      DRAIN: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- shadow registers / row-valid flags ----------------
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      next_line_reg <= 10'd0;
      valid_sh_reg  <= '0;
      row_valid_reg <= '0;
    end else begin
      if (fetch_start) begin
        next_line_reg <= (DrawY == 10'd524) ? 10'd0 : DrawY + 10'd1;
        valid_sh_reg  <= slot_valid;
      end
      if (state_reg == SCAN)
        row_valid_reg[slot_reg] <= scan_hit;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (fetch_start) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        x_sh_reg[i]   <= slot_x[10*i +: 10];
        y_sh_reg[i]   <= slot_y[10*i +: 10];
        dir_sh_reg[i] <= slot_dir[2*i +: 2];
      end
    end
  end

  // ---------------- per-slot row buffers and texel lookup ----------------
  genvar gi;
  generate
    for (gi = 0; gi < N_SLOTS; gi++) begin : g_slot
      logic [3:0] rowbuf [32];
      logic [9:0] col_off;

      always_ff @(posedge vga_clk) begin
        if (wr_en_reg && (wr_slot_reg == 2'(gi)))
          rowbuf[wr_col_reg] <= rom_q;
      end

      assign col_off                = DrawX - x_sh_reg[gi];
      assign texel_flat[4*gi +: 4]  = rowbuf[col_off[4:0]];
      assign live[gi] = row_valid_reg[gi] && (DrawX < 10'd640) &&
                        (col_off < 10'd32) && (rowbuf[col_off[4:0]] != 4'd0);
    end
  endgenerate

  // Scan from the highest slot down so the lowest live slot overwrites last.
  always_comb begin
    hit_next = 1'b0;
    idx_next = 4'd0;
    slot_win = 2'd0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (live[i]) begin
        hit_next = 1'b1;
        idx_next = texel_flat[4*i +: 4];
        slot_win = 2'(i);
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      sprite_hit_reg  <= 1'b0;
      sprite_idx_reg  <= 4'd0;
      sprite_slot_reg <= 2'd0;
    end else begin
      sprite_hit_reg  <= hit_next;
      sprite_idx_reg  <= idx_next;
      sprite_slot_reg <= slot_win;
    end
  end

  assign sprite_hit  = sprite_hit_reg;
  assign sprite_idx  = sprite_idx_reg;
  assign sprite_slot = sprite_slot_reg;

`ifdef TANK_SCHED_COLLIDE_EN
  logic [2:0] live_count;
  logic       collision_reg;

  always_comb begin
    live_count = 3'd0;
    for (int i = 0; i < N_SLOTS; i++)
      live_count = live_count + 3'(live[i]);
  end

  // Set has priority over the frame-origin clear.
  always_ff @(posedge vga_clk) begin
    if (Reset)
      collision_reg <= 1'b0;
    else if (live_count >= 3'd2)
      collision_reg <= 1'b1;
    else if ((DrawX == 10'd0) && (DrawY == 10'd0))
      collision_reg <= 1'b0;
  end

  assign collision = collision_reg;
`else
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_tank_sprite_scheduler.sv
// Testbench for tank_sprite_scheduler: drives DrawX/DrawY line by line with a
// bench-side synchronous ROM and compares every output against a model that
// evaluates the sprite rules directly from the slot state captured at each
// fetch start.
module tb_tank_sprite_scheduler;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            Reset;
  logic [9:0]      DrawX, DrawY;
  logic [N-1:0]    slot_valid;
  logic [10*N-1:0] slot_x, slot_y;
  logic [2*N-1:0]  slot_dir;
  logic [11:0]     rom_address;
  logic [3:0]      rom_q;
  logic            sprite_hit;
  logic [3:0]      sprite_idx;
  logic [1:0]      sprite_slot;
  logic            fetch_busy;
  logic            collision;

  logic [3:0] rom_mem [4096];

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom_mem[rom_address];

  tank_sprite_scheduler #(.N_SLOTS(N)) dut (
    .vga_clk(clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .slot_valid(slot_valid), .slot_x(slot_x), .slot_y(slot_y),
    .slot_dir(slot_dir), .rom_address(rom_address), .rom_q(rom_q),
    .sprite_hit(sprite_hit), .sprite_idx(sprite_idx),
    .sprite_slot(sprite_slot), .fetch_busy(fetch_busy),
    .collision(collision)
  );

  int checks = 0;
  int errors = 0;

  // State the model believes the DUT latched at the last fetch start.
  int snap_v [N];
  int snap_x [N];
  int snap_y [N];
  int snap_d [N];
  int snap_line;
  bit snap_ok = 1'b0;
  bit col_exp = 1'b0;
  int last_busy;
  logic [6:0] line_out [640];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int x, input int y);
    @(negedge clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    @(posedge clk);
    #1;
  endtask

  function automatic void set_slot(input int s, input bit v, input int x, input int y, input int d);
    slot_valid[s]       = v;
    slot_x[10*s +: 10]  = 10'(x);
    slot_y[10*s +: 10]  = 10'(y);
    slot_dir[2*s +: 2]  = 2'(d);
  endfunction

  // Sprite rule: row/column are 10-bit unsigned differences, texel 0 is clear,
  // lowest slot with a visible texel wins.
  function automatic void expect_pixel(input int x, output int hit, output int idx,
                                       output int sl, output int nlive);
    hit = 0; idx = 0; sl = 0; nlive = 0;
    if (snap_ok && x < 640 && snap_line < 480) begin
      for (int s = 0; s < N; s++) begin
        int r, c, t;
        r = (snap_line - snap_y[s]) & 1023;
        c = (x - snap_x[s]) & 1023;
        if (snap_v[s] != 0 && r < 32 && c < 32) begin
          t = int'(rom_mem[snap_d[s]*1024 + r*32 + c]);
          if (t != 0) begin
            nlive++;
            if (hit == 0) begin hit = 1; idx = t; sl = s; end
          end
        end
      end
    end
  endfunction

  task automatic check_pixel(input int x, input int y, input bit rst);
    int h, idx, sl, nl;
    expect_pixel(x, h, idx, sl, nl);
    if (rst) col_exp = 1'b0;
`ifdef TANK_SCHED_COLLIDE_EN
    else if (nl >= 2) col_exp = 1'b1;
    else if (x == 0 && y == 0) col_exp = 1'b0;
`endif
    chk($sformatf("pix y=%0d x=%0d", y, x),
        {sprite_hit, sprite_idx, sprite_slot, collision},
        {1'(h), 4'(idx), 2'(sl), col_exp});
  endtask

  // One hblank on line prev_y (fetching the next line) then the active part of
  // the next line. reset_at >= 0 pulses Reset on that hblank cycle.
  task automatic run_line(input int prev_y, input int reset_at, input bit mid_change);
    int exp_addr [160];
    int k, total, busy_cnt, cur;
    bit exp_busy;
    snap_line = (prev_y == 524) ? 0 : prev_y + 1;
    cur = snap_line;
    for (int s = 0; s < N; s++) begin
      snap_v[s] = int'(slot_valid[s]);
      snap_x[s] = int'(slot_x[10*s +: 10]);
      snap_y[s] = int'(slot_y[10*s +: 10]);
      snap_d[s] = int'(slot_dir[2*s +: 2]);
    end
    snap_ok = 1'b1;
    for (int i = 0; i < 160; i++) exp_addr[i] = 0;
    // Schedule: one scan cycle per slot, 32 fetch cycles per hit slot, drain.
    k = 0;
    for (int s = 0; s < N; s++) begin
      int r;
      r = (snap_line - snap_y[s]) & 1023;
      k++;
      if (snap_v[s] != 0 && snap_line < 480 && r < 32) begin
        for (int c = 0; c < 32; c++) begin
          exp_addr[k] = snap_d[s]*1024 + r*32 + c;
          k++;
        end
      end
    end
    total = k + 1;
    busy_cnt = 0;
    for (int i = 0; i < 160; i++) begin
      Reset = (i == reset_at);
      tick(640 + i, prev_y);
      if (i == reset_at) snap_ok = 1'b0;
      exp_busy = (i < total) && !(reset_at >= 0 && i >= reset_at);
      chk($sformatf("fetch y=%0d k=%0d", prev_y, i), {fetch_busy, rom_address},
          {exp_busy, exp_busy ? 12'(exp_addr[i]) : 12'd0});
      busy_cnt += int'(fetch_busy);
      check_pixel(640 + i, prev_y, i == reset_at);
    end
    Reset = 1'b0;
    last_busy = busy_cnt;
    if (reset_at < 0) chk($sformatf("busy_len y=%0d", prev_y), busy_cnt, total);
    for (int x = 0; x < 640; x++) begin
      if (mid_change && x == 320)
        for (int s = 0; s < N; s++) slot_x[10*s +: 10] = 10'($urandom_range(0, 639));
      tick(x, cur);
      line_out[x] = {sprite_hit, sprite_idx, sprite_slot};
      check_pixel(x, cur, 1'b0);
    end
  endtask

  initial begin
    bit any;
    for (int i = 0; i < 4096; i++)
      rom_mem[i] = ($urandom_range(0, 9) < 4) ? 4'd0 : 4'($urandom_range(1, 15));
    slot_valid = '0; slot_x = '0; slot_y = '0; slot_dir = '0;
    DrawX = 10'd0; DrawY = 10'd0; Reset = 1'b1;
    for (int i = 0; i < 3; i++) tick(0, 0);
    chk("reset_state", {sprite_hit, sprite_idx, sprite_slot, fetch_busy, collision, rom_address},
        '0);
    Reset = 1'b0;

    // Single slot: texel (row 5, col 3) of dir 1 at pixel (103,55).
    set_slot(0, 1'b1, 100, 50, 1);
    rom_mem[{2'd1, 5'd5, 5'd3}] = 4'hA;
    run_line(54, -1, 1'b0);
    chk("single x103", line_out[103], {1'b1, 4'hA, 2'd0});
    chk("single x99",  line_out[99][6],  1'b0);
    chk("single x132", line_out[132][6], 1'b0);

    // All four slots hit the same line: 133-cycle fetch.
    for (int s = 0; s < N; s++) set_slot(s, 1'b1, 300 + 20*s, 190 + 2*s, s);
    run_line(200, -1, 1'b0);
    chk("busy133", last_busy, 133);

    // Slots 0 and 2 overlap; slot 0 transparent at col 10.
    set_slot(1, 1'b0, 0, 0, 0);
    set_slot(3, 1'b0, 0, 0, 0);
    set_slot(0, 1'b1, 200, 100, 0);
    set_slot(2, 1'b1, 210, 100, 2);
    rom_mem[{2'd0, 5'd5, 5'd10}] = 4'h0;
    rom_mem[{2'd2, 5'd5, 5'd0}]  = 4'h7;
    rom_mem[{2'd0, 5'd5, 5'd11}] = 4'h3;
    rom_mem[{2'd2, 5'd5, 5'd1}]  = 4'h9;
    run_line(104, -1, 1'b0);
    chk("overlap x210", line_out[210], {1'b1, 4'h7, 2'd2});
    chk("overlap x211", line_out[211], {1'b1, 4'h3, 2'd0});

    // Frame wrap: line 524 fetches line 0.
    set_slot(2, 1'b0, 0, 0, 0);
    set_slot(0, 1'b1, 300, 0, 3);
    run_line(524, -1, 1'b0);
    chk("wrap_busy", last_busy, 37);

    // Bottom edge: y=470 fetched for line 479, never for line 480.
    set_slot(0, 1'b1, 600, 470, 1);
    run_line(478, -1, 1'b0);
    chk("row9_busy", last_busy, 37);
    run_line(479, -1, 1'b0);
    chk("line480_busy", last_busy, 5);

    // Mid-line x change only affects the following line.
    for (int s = 0; s < N; s++) set_slot(s, 1'b1, $urandom_range(0, 639), 290 + 3*s, s);
    run_line(300, -1, 1'b1);
    run_line(301, -1, 1'b0);

    // Reset 40 cycles into a fetch: nothing rendered on the next line.
    for (int s = 0; s < N; s++) set_slot(s, 1'b1, 100 + 40*s, 140 + s, 3 - s);
    run_line(150, 40, 1'b0);
    any = 1'b0;
    for (int x = 0; x < 640; x++) any |= line_out[x][6];
    chk("post_reset_quiet", any, 1'b0);
    run_line(151, -1, 1'b0);

    // Randomized lines.
    for (int n = 0; n < 10; n++) begin
      int py;
      py = $urandom_range(45, 470);
      for (int s = 0; s < N; s++)
        set_slot(s, $urandom_range(0, 3) != 0, $urandom_range(0, 639),
                 py + 1 - $urandom_range(0, 45), $urandom_range(0, 3));
      run_line(py, -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
